// File: rtl/ir_nec_decoder.sv
// -----------------------------------------------------------------------------
// ir_nec_decoder
//
// Decodes NEC infrared remote frames from a demodulated IR receiver output.
// A data frame is a 9 ms burst, a 4.5 ms space and 32 pulse-distance bits sent
// LSB first: address, ~address, command, ~command. A repeat frame is a 9 ms
// burst, a 2.25 ms space and a stop burst. All timing windows are given in
// sys_clk cycles and are inclusive.
//
// Ports
//   sys_clk      in   1  single clock, everything on its rising edge
//   sys_rst_n    in   1  synchronous active-low reset
//   infrared_in  in   1  asynchronous IR receiver output (idle high, burst low)
//   addr         out  8  address byte of the last accepted frame
//   data         out  8  command byte of the last accepted frame
//   data_vld     out  1  one-cycle pulse when a frame is accepted
//   repeat_en    out  1  one-cycle pulse per accepted repeat frame
//
// Build option
//   IR_NEC_INV_CHECK_EN  when defined, a frame is accepted only if both
//                        inverse bytes match; otherwise every complete 32-bit
//                        frame is accepted and the inverse bytes are ignored.
// -----------------------------------------------------------------------------
module ir_nec_decoder #(
  parameter int unsigned LEAD_LO_MIN = 400_000,
  parameter int unsigned DATA_HI_MIN = 200_000,
  parameter int unsigned DATA_HI_MAX = 250_000,
  parameter int unsigned REP_HI_MIN  = 100_000,
  parameter int unsigned REP_HI_MAX  = 125_000,
  parameter int unsigned BIT_LO_MIN  = 20_000,
  parameter int unsigned BIT_LO_MAX  = 35_000,
  parameter int unsigned ONE_HI_MIN  = 75_000,
  parameter int unsigned ONE_HI_MAX  = 95_000,
  parameter int unsigned TIMEOUT     = 600_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       infrared_in,
  output logic [7:0] addr,
  output logic [7:0] data,
  output logic       data_vld,
  output logic       repeat_en
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LEAD_LO = 3'd1;
  localparam logic [2:0] LEAD_HI = 3'd2;
  localparam logic [2:0] BIT_LO  = 3'd3;
  localparam logic [2:0] BIT_HI  = 3'd4;

  localparam logic [19:0] TIMEOUT_C = TIMEOUT[19:0];

  // ---------------------------------------------------------------------------
  // Input synchronisation and edge detection
  // ---------------------------------------------------------------------------
  logic ir_s1;
  logic ir_s2;
  logic ir_d;
  logic fall;
  logic rise;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ir_s1 <= 1'b1;
      ir_s2 <= 1'b1;
      ir_d  <= 1'b1;
    end else begin
      ir_s1 <= infrared_in;
      ir_s2 <= ir_s1;
      ir_d  <= ir_s2;
    end
  end

  assign fall = ir_d & ~ir_s2;
  assign rise = ~ir_d & ir_s2;

  // ---------------------------------------------------------------------------
  // Duration counter
  // ---------------------------------------------------------------------------
  logic [2:0]  state;
  logic [19:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (state == IDLE || fall || rise) begin
      cnt <= '0;
    end else if (cnt < TIMEOUT_C) begin
      cnt <= cnt + 20'd1;
    end
  end

  // The counter is cleared on the edge that starts a level, so when the edge
  // that ends it is seen the counter holds (level length - 1). Windows are
  // applied to the true level length in clocks.
  logic [31:0] dur;
  assign dur = {12'd0, cnt} + 32'd1;

  function automatic logic in_win(input logic [31:0] v,
                                  input int unsigned lo,
                                  input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

  logic timeout;
  logic lead_ok;
  logic data_sp;
  logic rep_sp;
  logic bit_zero;
  logic bit_one;

  assign timeout  = (state != IDLE) && (cnt == TIMEOUT_C);
  assign lead_ok  = (dur >= LEAD_LO_MIN);
  assign data_sp  = in_win(dur, DATA_HI_MIN, DATA_HI_MAX);
  assign rep_sp   = in_win(dur, REP_HI_MIN, REP_HI_MAX);
  // Burst window and zero-space window share the same bounds.
  assign bit_zero = in_win(dur, BIT_LO_MIN, BIT_LO_MAX);
  assign bit_one  = in_win(dur, ONE_HI_MIN, ONE_HI_MAX);

  // ---------------------------------------------------------------------------
  // Frame assembly and check
  // ---------------------------------------------------------------------------
  logic [4:0]  bit_cnt;
  logic [31:0] shift;
  logic [31:0] word;
  logic        frame_ok;
  logic        rep_ok;

  // Completed frame as it will look once the 32nd bit lands in shift[31];
  // evaluating it in the same cycle keeps the pulse latency at three clocks.
  assign word = {bit_one, shift[30:0]};

`ifdef IR_NEC_INV_CHECK_EN
  assign frame_ok = (word[15:8] == ~word[7:0]) && (word[31:24] == ~word[23:16]);

  logic unused_bits;
  assign unused_bits = shift[31];
`else
  assign frame_ok = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{shift[31], word[31:24], word[15:8]};
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      addr      <= '0;
      data      <= '0;
      data_vld  <= 1'b0;
      repeat_en <= 1'b0;
      rep_ok    <= 1'b0;
    end else begin
      data_vld  <= 1'b0;
      repeat_en <= 1'b0;

      if (timeout) begin
        state   <= IDLE;
        bit_cnt <= '0;
        rep_ok  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // A rise here is the end of a stop burst and carries no meaning.
            if (fall) begin
              state <= LEAD_LO;
            end
          end

          LEAD_LO: begin
            if (rise) begin
              state <= lead_ok ? LEAD_HI : IDLE;
            end
          end

          LEAD_HI: begin
            if (fall) begin
              if (data_sp) begin
                state   <= BIT_LO;
                bit_cnt <= '0;
              end else if (rep_sp) begin
                repeat_en <= rep_ok;
                state     <= IDLE;
              end else begin
                state <= IDLE;
              end
            end
          end

          BIT_LO: begin
            if (rise) begin
              state <= bit_zero ? BIT_HI : IDLE;
            end
          end

          BIT_HI: begin
            if (fall) begin
              if (bit_zero || bit_one) begin
                shift[bit_cnt] <= bit_one;
                if (bit_cnt == 5'd31) begin
                  state <= IDLE;
                  if (frame_ok) begin
                    addr     <= word[7:0];
                    data     <= word[23:16];
                    data_vld <= 1'b1;
                    rep_ok   <= 1'b1;
                  end else begin
                    rep_ok <= 1'b0;
                  end
                end else begin
                  bit_cnt <= bit_cnt + 5'd1;
                  state   <= BIT_LO;
                end
              end else begin
                state <= IDLE;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// -----------------------------------------------------------------------------
// tb_ir_nec_decoder
//
// Drives scaled-down NEC waveforms into ir_nec_decoder. Expected pulses are
// queued when the deciding falling edge is driven and matched against the
// decoder's data_vld / repeat_en pulses (kind, cycle, addr, data).
// -----------------------------------------------------------------------------
module tb_ir_nec_decoder;

  // Timing scaled down by 1000 from the 50 MHz figures.
  localparam int unsigned P_LEAD_LO_MIN = 400;
  localparam int unsigned P_DATA_HI_MIN = 200;
  localparam int unsigned P_DATA_HI_MAX = 250;
  localparam int unsigned P_REP_HI_MIN  = 100;
  localparam int unsigned P_REP_HI_MAX  = 125;
  localparam int unsigned P_BIT_LO_MIN  = 20;
  localparam int unsigned P_BIT_LO_MAX  = 35;
  localparam int unsigned P_ONE_HI_MIN  = 75;
  localparam int unsigned P_ONE_HI_MAX  = 95;
  localparam int unsigned P_TIMEOUT     = 600;

  localparam int unsigned T_LEAD  = 450;  // 9 ms
  localparam int unsigned T_DSP   = 225;  // 4.5 ms
  localparam int unsigned T_RSP   = 112;  // 2.25 ms
  localparam int unsigned T_BIT   = 28;   // 560 us
  localparam int unsigned T_ONE   = 84;   // 1.69 ms
  localparam int unsigned T_GAP   = 200;
  localparam int unsigned T_STUCK = 750;  // 15 ms

`ifdef IR_NEC_INV_CHECK_EN
  localparam logic INV_CHK = 1'b1;
`else
  localparam logic INV_CHK = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       infrared_in;
  logic [7:0] addr;
  logic [7:0] data;
  logic       data_vld;
  logic       repeat_en;

  ir_nec_decoder #(
    .LEAD_LO_MIN (P_LEAD_LO_MIN),
    .DATA_HI_MIN (P_DATA_HI_MIN),
    .DATA_HI_MAX (P_DATA_HI_MAX),
    .REP_HI_MIN  (P_REP_HI_MIN),
    .REP_HI_MAX  (P_REP_HI_MAX),
    .BIT_LO_MIN  (P_BIT_LO_MIN),
    .BIT_LO_MAX  (P_BIT_LO_MAX),
    .ONE_HI_MIN  (P_ONE_HI_MIN),
    .ONE_HI_MAX  (P_ONE_HI_MAX),
    .TIMEOUT     (P_TIMEOUT)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .infrared_in (infrared_in),
    .addr        (addr),
    .data        (data),
    .data_vld    (data_vld),
    .repeat_en   (repeat_en)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic        kind;   // 0 = data_vld, 1 = repeat_en
    logic [7:0]  a;
    logic [7:0]  d;
    int unsigned c;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  na;
    logic [7:0]  d;
    logic [7:0]  nd;
    int unsigned lead;
    int unsigned one_sp;
    logic        vld;
    logic [7:0]  ea;
    logic [7:0]  ed;
    logic        do_rep;
    logic        rep;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hold infrared_in at v for n clocks; always entered and left at a negedge.
  task automatic seg(input logic v, input int unsigned n);
    infrared_in = v;
    repeat (n) @(negedge sys_clk);
  endtask

  // Called just before driving the deciding fall: the pulse must appear on
  // the third rising edge after it.
  task automatic push_exp(input logic kind, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.kind = kind;
    e.a    = a;
    e.d    = d;
    e.c    = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected pulse(s) never seen, required 0 outstanding", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] na,
                            input logic [7:0] d, input logic [7:0] nd,
                            input int unsigned lead, input int unsigned one_sp,
                            input logic exp_vld);
    logic [31:0] w;
    w = {nd, d, na, a};
    seg(1'b0, lead);
    seg(1'b1, T_DSP);
    for (int i = 0; i < 32; i++) begin
      seg(1'b0, T_BIT);
      seg(1'b1, w[i] ? one_sp : T_BIT);
    end
    if (exp_vld) push_exp(1'b0, a, d);
    seg(1'b0, T_BIT);
    seg(1'b1, T_GAP);
  endtask

  task automatic send_repeat(input logic exp_rep, input logic [7:0] a, input logic [7:0] d);
    seg(1'b0, T_LEAD);
    seg(1'b1, T_RSP);
    if (exp_rep) push_exp(1'b1, a, d);
    seg(1'b0, T_BIT);
    seg(1'b1, T_GAP);
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge sys_clk);
          if (sys_rst_n && (data_vld || repeat_en)) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_pulse: data_vld=%0b repeat_en=%0b at cycle %0d, required no pulse",
                       data_vld, repeat_en, cyc);
            end else begin
              e = sb.pop_front();
              chk("pulse_kind", {31'd0, repeat_en}, {31'd0, e.kind});
              chk("pulse_single_kind", {31'd0, data_vld & repeat_en}, 32'd0);
              chk("pulse_cycle", cyc, e.c);
              chk("pulse_addr", {24'd0, addr}, {24'd0, e.a});
              chk("pulse_data", {24'd0, data}, {24'd0, e.d});
            end
          end
        end
      end
      begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
      end
    join_none
  end

  initial begin
    logic [31:0] w;

    // {a, ~a, d, ~d, leader, one-space, vld, exp addr, exp data, repeat?, rep pulse}
    tbl[0] = '{8'h00, 8'hFF, 8'h45, 8'hBA, T_LEAD, T_ONE, 1'b1, 8'h00, 8'h45, 1'b1, 1'b1};
    tbl[1] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, T_LEAD, T_ONE, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b0};
    tbl[2] = '{8'h12, 8'hED, 8'h45, 8'h00, T_LEAD, T_ONE, !INV_CHK,
               INV_CHK ? 8'hA5 : 8'h12, INV_CHK ? 8'h3C : 8'h45, 1'b1, !INV_CHK};
    tbl[3] = '{8'h5A, 8'hA5, 8'h11, 8'hEE, 350, T_ONE, 1'b0,
               INV_CHK ? 8'hA5 : 8'h12, INV_CHK ? 8'h3C : 8'h45, 1'b0, 1'b0};
    tbl[4] = '{8'h5A, 8'hA5, 8'h11, 8'hEE, T_LEAD, 60, 1'b0,
               INV_CHK ? 8'hA5 : 8'h12, INV_CHK ? 8'h3C : 8'h45, 1'b0, 1'b0};
    tbl[5] = '{8'h81, 8'h7E, 8'hE7, 8'h18, T_LEAD, P_ONE_HI_MAX, 1'b1, 8'h81, 8'hE7, 1'b0, 1'b0};
    tbl[6] = '{8'h42, 8'hBD, 8'h24, 8'hDB, T_LEAD, P_ONE_HI_MAX + 1, 1'b0, 8'h81, 8'hE7, 1'b0, 1'b0};
    tbl[7] = '{8'h3C, 8'hC3, 8'h0F, 8'hF0, P_LEAD_LO_MIN, T_ONE, 1'b1, 8'h3C, 8'h0F, 1'b1, 1'b1};

    sys_rst_n   = 1'b0;
    infrared_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("reset_addr", {24'd0, addr}, 32'd0);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_data_vld", {31'd0, data_vld}, 32'd0);
    chk("reset_repeat_en", {31'd0, repeat_en}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Repeat with no prior frame must not pulse.
    send_repeat(1'b0, 8'h00, 8'h00);
    drain("repeat_after_reset");

    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].a, tbl[i].na, tbl[i].d, tbl[i].nd,
                 tbl[i].lead, tbl[i].one_sp, tbl[i].vld);
      drain("frame_pulse");
      chk("frame_addr", {24'd0, addr}, {24'd0, tbl[i].ea});
      chk("frame_data", {24'd0, data}, {24'd0, tbl[i].ed});
      if (tbl[i].do_rep) begin
        send_repeat(tbl[i].rep, tbl[i].ea, tbl[i].ed);
        drain("repeat_pulse");
      end
    end

    // Stuck low mid-frame: timeout to IDLE, repeat permission withdrawn.
    w = {8'hAA, 8'h55, 8'hFF, 8'h00};
    seg(1'b0, T_LEAD);
    seg(1'b1, T_DSP);
    for (int i = 0; i < 10; i++) begin
      seg(1'b0, T_BIT);
      seg(1'b1, w[i] ? T_ONE : T_BIT);
    end
    seg(1'b0, T_STUCK);
    seg(1'b1, T_GAP);
    drain("timeout_no_pulse");
    send_repeat(1'b0, 8'h3C, 8'h0F);
    drain("repeat_after_timeout");
    chk("timeout_hold_addr", {24'd0, addr}, 32'h3C);
    chk("timeout_hold_data", {24'd0, data}, 32'h0F);

    send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, T_LEAD, T_ONE, 1'b1);
    drain("frame_after_timeout");

    // One-clock reset during bit 20.
    w = {8'h3C, 8'hC3, 8'h96, 8'h69};
    seg(1'b0, T_LEAD);
    seg(1'b1, T_DSP);
    for (int i = 0; i < 32; i++) begin
      if (i == 20) begin
        seg(1'b0, 10);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        chk("midreset_addr", {24'd0, addr}, 32'd0);
        chk("midreset_data", {24'd0, data}, 32'd0);
        chk("midreset_data_vld", {31'd0, data_vld}, 32'd0);
        chk("midreset_repeat_en", {31'd0, repeat_en}, 32'd0);
        repeat (T_BIT - 11) @(negedge sys_clk);
      end else begin
        seg(1'b0, T_BIT);
      end
      seg(1'b1, w[i] ? T_ONE : T_BIT);
    end
    seg(1'b0, T_BIT);
    seg(1'b1, T_GAP);
    drain("midreset_no_pulse");
    chk("midreset_end_addr", {24'd0, addr}, 32'd0);
    chk("midreset_end_data", {24'd0, data}, 32'd0);
    send_repeat(1'b0, 8'h00, 8'h00);
    drain("repeat_after_midreset");

    send_frame(8'h77, 8'h88, 8'h99, 8'h66, T_LEAD, T_ONE, 1'b1);
    drain("final_frame");
    chk("final_addr", {24'd0, addr}, 32'h77);
    chk("final_data", {24'd0, data}, 32'h99);

    repeat (10) @(negedge sys_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_nec_decoder.md
IR_NEC_DECODER -- requirements
Module: ir_nec_decoder

Interface
REQ-001 SHALL have parameter LEAD_LO_MIN, 400_000, minimum leader burst (low) length in clocks (8 ms at 50 MHz).
REQ-002 SHALL have parameter DATA_HI_MIN / DATA_HI_MAX, 200_000 / 250_000, data-frame leader space window.
REQ-003 SHALL have parameter REP_HI_MIN / REP_HI_MAX, 100_000 / 125_000, repeat-frame leader space window.
REQ-004 SHALL have parameter BIT_LO_MIN / BIT_LO_MAX, 20_000 / 35_000, bit burst window; the zero-space window is the same.
REQ-005 SHALL have parameter ONE_HI_MIN / ONE_HI_MAX, 75_000 / 95_000, one-bit space window.
REQ-006 SHALL have parameter TIMEOUT, 600_000, maximum time in any non-idle state.
REQ-007 SHALL have port sys_clk, input, 1, single clock; all logic is on its rising edge.
REQ-008 SHALL have port sys_rst_n, input, 1, reset; synchronous, active-low.
REQ-009 SHALL have port infrared_in, input, 1, asynchronous IR receiver output; idle high, burst low.
REQ-010 SHALL have port addr, output, 8, address byte of the last accepted frame.
REQ-011 SHALL have port data, output, 8, command byte of the last accepted frame.
REQ-012 SHALL have port data_vld, output, 1, one-cycle pulse on frame acceptance.
REQ-013 SHALL have port repeat_en, output, 1, one-cycle pulse per accepted repeat frame; feeds the LED stage's rise detector.

Function
REQ-014 SHALL pass infrared_in through two sync flops plus one delay flop; fall = delayed & ~synced; rise = ~delayed & synced.
REQ-015 SHALL use a 20-bit duration counter: cleared on any edge and in IDLE, otherwise incremented, saturating at TIMEOUT.
REQ-016 SHALL implement the FSM states IDLE, LEAD_LO, LEAD_HI, BIT_LO, BIT_HI.
REQ-017 IDLE SHALL move to LEAD_LO on fall; rise in IDLE (stop-burst end) is ignored.
REQ-018 LEAD_LO SHALL, on rise, go to LEAD_HI if count >= LEAD_LO_MIN, else to IDLE.
REQ-019 LEAD_HI SHALL, on fall: count in data window -> BIT_LO with bit_cnt=0; count in repeat window -> pulse repeat_en if rep_ok=1, then IDLE; otherwise IDLE.
REQ-020 BIT_LO SHALL, on rise, go to BIT_HI if count is in the bit window, else to IDLE.
REQ-021 BIT_HI SHALL, on fall: zero window -> bit 0; one window -> bit 1; otherwise IDLE with the frame discarded.
REQ-022 A classified bit SHALL be written to shift[bit_cnt], LSB first; at bit_cnt=31 the FSM goes to IDLE and evaluates the frame, else to BIT_LO with bit_cnt+1.
REQ-023 Frame layout SHALL be shift[7:0]=addr, [15:8]=~addr, [23:16]=data, [31:24]=~data.
REQ-024 An accepted frame SHALL update addr/data, pulse data_vld, and set rep_ok in the same cycle.
REQ-025 A rejected frame SHALL leave addr/data unchanged and clear rep_ok.
REQ-026 Latency: data_vld/repeat_en SHALL be high exactly on the 3rd sys_clk rising edge after the deciding infrared_in falling edge, for one cycle.
REQ-027 Counter reaching TIMEOUT in any non-IDLE state SHALL force IDLE, discard the partial frame, and clear rep_ok.
REQ-028 Window bounds SHALL be inclusive.
REQ-029 Edges arriving during the FSM's evaluation cycle SHALL be handled by the next state (no lost fall after IDLE).

Reset
REQ-030 With sys_rst_n low at a sys_clk edge: state=IDLE; counter, bit_cnt, shift, addr, data = 0; data_vld, repeat_en, rep_ok = 0; sync/delay flops = 1.
REQ-031 Reset mid-frame SHALL abandon the frame; no data_vld or repeat_en pulse SHALL follow from pre-reset edges.

Configuration
REQ-032 With macro IR_NEC_INV_CHECK_EN defined, a frame SHALL be accepted only if shift[15:8]==~shift[7:0] and shift[31:24]==~shift[23:16].
REQ-033 With IR_NEC_INV_CHECK_EN undefined, every complete 32-bit frame SHALL be accepted and the inverse bytes ignored.

Verification
REQ-034 SHALL cover: NEC frame addr=0x00, data=0x45 (inverses correct) -> one data_vld pulse, addr=0x00, data=0x45, 3 clocks after the 32nd bit's closing fall.
REQ-035 SHALL cover: valid frame, then repeat frame (9 ms burst, 2.25 ms space, 560 us burst) -> one repeat_en pulse, no data_vld; a repeat after reset with no prior frame -> no pulse.
REQ-036 SHALL cover: frame with data=0x45, ~data=0x00 -> with IR_NEC_INV_CHECK_EN: no data_vld, outputs hold, a following repeat gives no pulse; without it: data_vld, data=0x45.
REQ-037 SHALL cover: leader burst of 7 ms, or a bit space of 1.2 ms -> return to IDLE, no pulses; the next good frame decodes normally.
REQ-038 SHALL cover: infrared_in stuck low 15 ms mid-frame -> IDLE after TIMEOUT; sys_rst_n low for 1 clock at bit 20 -> all outputs 0, no pulses.
REQ-039 SHALL cover: boundary cases with bit space = ONE_HI_MAX (accepted) and ONE_HI_MAX+1 clocks (rejected), with parameters scaled down for runtime.
